rand_dir_sampler: RTL and testbench

RAND_DIR_SAMPLER -- requirements
Module: rand_dir_sampler

---
 rtl/rand_dir_sampler_pkg.sv | 29 ++
 rtl/rand_dir_sampler.sv | 156 +++++++++++++++
 tb/tb_rand_dir_sampler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_dir_sampler_pkg.sv
// rand_dir_sampler_pkg
// Shared enemy-control definitions for the random direction sampler.
//   dir_t        : movement direction, UP/RIGHT/DOWN/LEFT encoded 0..3
//   state_t      : sampler FSM states
//   *_DEFAULT    : default values for the sampler parameters
package rand_dir_sampler_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Shortest move (in frames) that is worth issuing.
  localparam int unsigned MIN_DUR_DEFAULT    = 8;
  // Random words examined per request before the deterministic fallback.
  localparam int unsigned MAX_TRIES_DEFAULT  = 8;
  // Longest run of identical consecutive directions.
  localparam int unsigned MAX_REPEAT_DEFAULT = 2;

endpackage

// File: rtl/rand_dir_sampler.sv
// rand_dir_sampler
// Draws a direction/duration pair from an external random generator on
// request. Words that are zero, too short, or would extend a run of
// identical directions past MAX_REPEAT are rejected; after MAX_TRIES
// rejections a deterministic fallback (next direction clockwise, MIN_DUR)
// is issued instead.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   req    in   level request, sampled only while idle
//   rnd_in in   9-bit random word: [1:0] dir, [2] unused, [8:3] duration
//   rnd_en out  enable for the random generator (high while priming/sampling)
//   dir    out  issued direction, held until the next valid pulse
//   dur    out  issued duration in frames, held until the next valid pulse
//   valid  out  one-cycle pulse when dir/dur are updated
//   busy   out  high whenever a transaction is in progress
module rand_dir_sampler
  import rand_dir_sampler_pkg::*;
#(
  parameter int unsigned MIN_DUR    = MIN_DUR_DEFAULT,
  parameter int unsigned MAX_TRIES  = MAX_TRIES_DEFAULT,
  parameter int unsigned MAX_REPEAT = MAX_REPEAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [8:0] rnd_in,
  output logic       rnd_en,
  output logic [1:0] dir,
  output logic [5:0] dur,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned REP_W = $clog2(MAX_REPEAT + 1);

  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(MAX_REPEAT);
  localparam logic [5:0]       MIN_DUR_W = 6'(MIN_DUR);

  state_t             state_q;
  logic               prime_cnt_q;
  logic [TRY_W-1:0]   try_cnt_q;
  dir_t               dir_q;
  dir_t               last_dir_q;
  logic [5:0]         dur_q;
  logic [REP_W-1:0]   repeat_cnt_q;
  logic               rnd_en_q;
  logic               valid_q;
  logic               busy_q;

  dir_t               cand_dir;
  logic [5:0]         cand_dur;
  logic               cand_reject;
  logic               tries_done;
  dir_t               fallback_dir;
  logic [REP_W-1:0]   repeat_next;

  // Bit 2 of the random word carries no meaning for this block.
  logic unused_rnd_bit;
  assign unused_rnd_bit = rnd_in[2];

  always_comb begin
    cand_dir     = dir_t'(rnd_in[1:0]);
    cand_dur     = rnd_in[8:3];
    cand_reject  = (rnd_in == 9'd0)
                || (cand_dur < MIN_DUR_W)
                || ((cand_dir == last_dir_q) && (repeat_cnt_q == REP_LIMIT));
    // The try counter reaches the limit on the cycle after the last
    // rejection; that cycle issues the fallback without looking at rnd_in.
    tries_done   = (try_cnt_q == TRY_LIMIT);
    fallback_dir = dir_t'(last_dir_q + 2'd1);
    // dir_q holds the value being issued while in DONE.
    if (dir_q == last_dir_q) begin
      repeat_next = (repeat_cnt_q == REP_LIMIT) ? REP_LIMIT : repeat_cnt_q + 1'b1;
    end else begin
      repeat_next = REP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prime_cnt_q  <= 1'b0;
      try_cnt_q    <= '0;
      dir_q        <= UP;
      last_dir_q   <= UP;
      dur_q        <= 6'd0;
      repeat_cnt_q <= '0;
      rnd_en_q     <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q     <= S_PRIME;
            prime_cnt_q <= 1'b0;
            try_cnt_q   <= '0;
            rnd_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        // Two cycles of enable before the first word is trusted, matching
        // the generator's enable-to-output latency.
        S_PRIME: begin
          if (prime_cnt_q) begin
            state_q <= S_SAMPLE;
          end else begin
            prime_cnt_q <= 1'b1;
          end
        end

        S_SAMPLE: begin
          if (tries_done) begin
            dir_q    <= fallback_dir;
            dur_q    <= MIN_DUR_W;
            valid_q  <= 1'b1;
            rnd_en_q <= 1'b0;
            state_q  <= S_DONE;
          end else if (!cand_reject) begin
            dir_q    <= cand_dir;
            dur_q    <= cand_dur;
            valid_q  <= 1'b1;
            rnd_en_q <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            try_cnt_q <= try_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          valid_q      <= 1'b0;
          busy_q       <= 1'b0;
          last_dir_q   <= dir_q;
          repeat_cnt_q <= repeat_next;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rnd_en = rnd_en_q;
  assign dir    = dir_q;
  assign dur    = dur_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rand_dir_sampler.sv
module tb_rand_dir_sampler;

  localparam int MIN_DUR    = 8;
  localparam int MAX_TRIES  = 8;
  localparam int MAX_REPEAT = 2;
  localparam int TIMEOUT    = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [8:0] rnd_in;
  logic       rnd_en;
  logic [1:0] dir;
  logic [5:0] dur;
  logic       valid;
  logic       busy;

  rand_dir_sampler #(
    .MIN_DUR   (MIN_DUR),
    .MAX_TRIES (MAX_TRIES),
    .MAX_REPEAT(MAX_REPEAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .rnd_in(rnd_in),
    .rnd_en(rnd_en),
    .dir   (dir),
    .dur   (dur),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Words presented on the SAMPLE cycles of the next transaction.
  logic [8:0] words [MAX_TRIES];

  // Reference model state: history of issued directions.
  int mdl_last = 0;
  int mdl_rep  = 0;

  // Observed transaction results.
  int         o_lat, o_en, o_busy;
  logic [1:0] o_d;
  logic [5:0] o_u;
  logic       o_env, o_pb, o_pe, o_pv;
  bit         o_to;
  // Expected transaction results.
  int         e_lat;
  logic [1:0] e_d;
  logic [5:0] e_u;

  // Reference: scan the words in order, first acceptable one wins; if none
  // of the MAX_TRIES words qualifies, fall back one step clockwise.
  task automatic model_txn();
    bit         found;
    logic [8:0] w;
    found = 1'b0;
    e_lat = 4 + MAX_TRIES;
    e_d   = 2'((mdl_last + 1) % 4);
    e_u   = 6'(MIN_DUR);
    for (int i = 0; i < MAX_TRIES; i++) begin
      w = words[i];
      if (!found && !(w == 9'd0 || int'(w[8:3]) < MIN_DUR ||
                      (int'(w[1:0]) == mdl_last && mdl_rep == MAX_REPEAT))) begin
        found = 1'b1;
        e_lat = 4 + i;
        e_d   = w[1:0];
        e_u   = w[8:3];
      end
    end
    if (int'(e_d) == mdl_last) mdl_rep = (mdl_rep < MAX_REPEAT) ? mdl_rep + 1 : MAX_REPEAT;
    else                       mdl_rep = 1;
    mdl_last = int'(e_d);
  endtask

  // Drives one transaction starting from an idle negedge; returns what was seen.
  task automatic run_txn(input bit drop_req, input bit hold_req);
    bit seen;
    int k;
    seen = 1'b0; o_to = 1'b0; o_lat = 0; o_d = '0; o_u = '0;
    o_en = 0; o_busy = 0; o_env = 1'b0; o_pb = 1'b0; o_pe = 1'b0; o_pv = 1'b0;
    req = 1'b1;
    k = 1;
    while (!seen && k <= TIMEOUT) begin
      @(negedge clk);
      if (busy) o_busy++;
      if (valid) begin
        seen = 1'b1; o_lat = k; o_d = dir; o_u = dur; o_env = rnd_en;
      end else if (rnd_en) begin
        o_en++;
      end
      if (drop_req) req = 1'b0;
      rnd_in = (k >= 3 && k - 3 < MAX_TRIES) ? words[k-3] : 9'($urandom);
      k++;
    end
    if (!seen) begin
      o_to = 1'b1;
      req  = 1'b0;
    end else begin
      @(negedge clk);
      o_pb = busy; o_pe = rnd_en; o_pv = valid;
      if (!hold_req) req = 1'b0;
    end
    $display("txn: lat=%0d dir=%0d dur=%0d rnd_en_cycles=%0d busy_cycles=%0d", o_lat, o_d, o_u, o_en, o_busy);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; rnd_in = 9'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rnd_en, valid, busy, dir, dur} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state: got rnd_en=%b valid=%b busy=%b dir=%0d dur=%0d, want all 0", rnd_en, valid, busy, dir, dur);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_try();
    for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'($urandom);
    words[0] = 9'h0A9;
    model_txn();
    run_txn(1'b1, 1'b0);
    checks++;
    if ({o_to, o_lat, o_d, o_u} !== {1'b0, 32'd4, 2'd1, 6'd21}) begin
      failures++;
      $display("FAIL first_try: got to=%b lat=%0d dir=%0d dur=%0d, want lat=4 dir=1 dur=21", o_to, o_lat, o_d, o_u);
    end
    checks++;
    if ({o_en, o_busy, o_env, o_pb, o_pe, o_pv} !== {32'd3, 32'd4, 4'b0000}) begin
      failures++;
      $display("FAIL first_try_proto: got en=%0d busy=%0d en@valid=%b post busy=%b en=%b valid=%b, want 3 4 0 0 0 0", o_en, o_busy, o_env, o_pb, o_pe, o_pv);
    end
  endtask

  task automatic test_rejections();
    for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'($urandom);
    words[0] = 9'h000; words[1] = 9'h012; words[2] = 9'h0C2;
    model_txn();
    run_txn(1'b0, 1'b0);
    checks++;
    if ({o_to, o_lat, o_d, o_u} !== {1'b0, 32'd6, 2'd2, 6'd24}) begin
      failures++;
      $display("FAIL rejections: got to=%b lat=%0d dir=%0d dur=%0d, want lat=6 dir=2 dur=24", o_to, o_lat, o_d, o_u);
    end
    checks++;
    if ({o_en, o_busy, o_env, o_pb, o_pe, o_pv} !== {32'd5, 32'd6, 4'b0000}) begin
      failures++;
      $display("FAIL rejections_proto: got en=%0d busy=%0d en@valid=%b post %b%b%b, want 5 6 0 000", o_en, o_busy, o_env, o_pb, o_pe, o_pv);
    end
  endtask

  task automatic test_repeat_limit();
    int exp_lat [3];
    int exp_dir [3];
    exp_lat = '{4, 4, 5};
    exp_dir = '{0, 0, 3};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'($urandom);
      words[0] = 9'h0C0; words[1] = 9'h0C3;
      model_txn();
      run_txn(1'b0, 1'b0);
      checks++;
      if (o_to || o_lat != exp_lat[t] || int'(o_d) != exp_dir[t] || o_u !== 6'd24) begin
        failures++;
        $display("FAIL repeat_limit[%0d]: got lat=%0d dir=%0d dur=%0d, want lat=%0d dir=%0d dur=24", t, o_lat, o_d, o_u, exp_lat[t], exp_dir[t]);
      end
    end
  endtask

  task automatic test_fallback();
    for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'($urandom);
    words[0] = 9'h0C2;
    model_txn();
    run_txn(1'b0, 1'b0);
    for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'h001;
    model_txn();
    run_txn(1'b0, 1'b0);
    checks++;
    if ({o_to, o_lat, o_d, o_u} !== {1'b0, 32'd12, 2'd3, 6'd8}) begin
      failures++;
      $display("FAIL fallback: got to=%b lat=%0d dir=%0d dur=%0d, want lat=12 dir=3 dur=8", o_to, o_lat, o_d, o_u);
    end
    checks++;
    if ({o_en, o_busy, o_env} !== {32'd11, 32'd12, 1'b0}) begin
      failures++;
      $display("FAIL fallback_proto: got en=%0d busy=%0d en@valid=%b, want 11 12 0", o_en, o_busy, o_env);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    saw_valid = 1'b0;
    req = 1'b1; rnd_in = 9'h000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (valid) saw_valid = 1'b1;
      rnd_in = 9'h000;
      if (k == 4) begin reset = 1'b1; req = 1'b0; end
    end
    @(negedge clk);
    if (valid) saw_valid = 1'b1;
    checks++;
    if ({saw_valid, rnd_en, valid, busy, dir, dur} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid: got saw_valid=%b rnd_en=%b valid=%b busy=%b dir=%0d dur=%0d, want all 0", saw_valid, rnd_en, valid, busy, dir, dur);
    end
    reset = 1'b0;
    mdl_last = 0; mdl_rep = 0;
    @(negedge clk);
    // Fallback direction exposes whether the direction history was cleared.
    for (int i = 0; i < MAX_TRIES; i++) words[i] = 9'h000;
    model_txn();
    run_txn(1'b0, 1'b0);
    checks++;
    if ({o_to, o_lat, o_d, o_u} !== {1'b0, 32'd12, 2'd1, 6'd8}) begin
      failures++;
      $display("FAIL reset_mid_after: got to=%b lat=%0d dir=%0d dur=%0d, want lat=12 dir=1 dur=8", o_to, o_lat, o_d, o_u);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < MAX_TRIES; i++) words[i] = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom);
      model_txn();
      run_txn(1'b0, t != 4);
      checks++;
      if (o_to || {o_lat, o_d, o_u} !== {e_lat, e_d, e_u}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got lat=%0d dir=%0d dur=%0d, want lat=%0d dir=%0d dur=%0d", t, o_lat, o_d, o_u, e_lat, e_d, e_u);
      end
      checks++;
      if ({o_en, o_env, o_pe, o_pb, o_pv} !== {e_lat - 1, 4'b0000}) begin
        failures++;
        $display("FAIL back_to_back_en[%0d]: got en=%0d en@done=%b en@idle=%b busy@idle=%b valid@idle=%b, want %0d 0 0 0 0", t, o_en, o_env, o_pe, o_pb, o_pv, e_lat - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < MAX_TRIES; i++) words[i] = {3'($urandom_range(0, 7) >> 1), 6'($urandom)} & 9'h03F;
      end else begin
        for (int i = 0; i < MAX_TRIES; i++) words[i] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      end
      model_txn();
      run_txn(1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (o_to || {o_lat, o_d, o_u} !== {e_lat, e_d, e_u}) begin
        failures++;
        $display("FAIL random[%0d]: got lat=%0d dir=%0d dur=%0d, want lat=%0d dir=%0d dur=%0d", t, o_lat, o_d, o_u, e_lat, e_d, e_u);
      end
      checks++;
      if ({o_en, o_busy, o_env, o_pb, o_pe, o_pv} !== {e_lat - 1, e_lat, 4'b0000}) begin
        failures++;
        $display("FAIL random_proto[%0d]: got en=%0d busy=%0d en@valid=%b post %b%b%b, want %0d %0d 0 000", t, o_en, o_busy, o_env, o_pb, o_pe, o_pv, e_lat - 1, e_lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; rnd_in = 9'd0;
    test_reset();
    test_first_try();
    test_rejections();
    test_repeat_limit();
    test_fallback();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
